// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   - FSM state encoding, access owner encoding
//   - default widths and watchdog limit
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int AW_DEF      = 7;
  localparam int DW_DEF      = 32;
  localparam int TIMEOUT_DEF = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake/bus signal around the arbiter: the IF-stage
// fetch port, the MEM-stage load/store port and the single memory port.
//   slave  : arbiter view (requests/memory responses in, acks/strobes out)
//   master : environment view (pipeline + memory model)
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          dm_rd;
  logic          dm_wr;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;

  logic          err_timeout;

  modport slave (
    input  if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_valid,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
           err_timeout
  );

  modport master (
    output if_req, if_addr, dm_rd, dm_wr, dm_addr, dm_wdata, mem_rdata, mem_valid,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
           err_timeout
  );
endinterface

// File: rtl/mem_arb_wdog.sv
// Access watchdog: counts cycles spent waiting for the memory.
//   clk, rst_n : clock / async active-low reset
//   clr_i      : restart from zero (on every grant)
//   en_i       : count this cycle (while waiting)
//   expired_o  : count has reached TIMEOUT-1
module mem_arb_wdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

  // Holds at the limit; the FSM leaves WAIT on expiry so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (en_i && !expired_o) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF)
// and data access (DM). One access at a time: issue, wait, respond.
//   clk, rst_n : clock / async active-low reset
//   bus        : mem_port_arbiter_if.slave (fetch port, data port, memory port)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | arbitrate; on grant register the access and strobe mem_en
// ST_WAIT | access outstanding; wait for mem_valid or watchdog expiry
// ST_RESP | one-cycle ack to the owner (plus err_timeout if expired)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);
  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          last_dm_q, last_dm_d;
  logic          to_q, to_d;
  logic          grant;
  logic          dm_req;
  logic          wd_clr, wd_en, wd_expired;

  mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expired_o(wd_expired)
  );

  assign dm_req = bus.dm_rd | bus.dm_wr;

  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dm_rdata    = dm_rdata_q;
  assign bus.if_ack      = (state_q == ST_RESP) && (owner_q == OWN_IF);
  assign bus.dm_ack      = (state_q == ST_RESP) && (owner_q == OWN_DM);
  assign bus.err_timeout = (state_q == ST_RESP) && to_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    mem_en_d   = 1'b0;
    last_dm_d  = last_dm_q;
    to_d       = to_q;
    grant      = 1'b0;
    wd_clr     = 1'b0;
    wd_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // DM wins unless it was served last and IF is also waiting,
        // which makes back-to-back contention strictly alternate.
        if (dm_req && (!bus.if_req || !last_dm_q)) begin
          grant   = 1'b1;
          owner_d = OWN_DM;
          we_d    = bus.dm_wr;   // rd+wr together is a write
          addr_d  = bus.dm_addr;
          wdata_d = bus.dm_wdata;
        end else if (bus.if_req) begin
          grant   = 1'b1;
          owner_d = OWN_IF;
          we_d    = 1'b0;
          addr_d  = bus.if_addr;
          wdata_d = '0;
        end
        if (grant) begin
          mem_en_d  = 1'b1;
          last_dm_d = (owner_d == OWN_DM);
          to_d      = 1'b0;
          wd_clr    = 1'b1;
          state_d   = ST_WAIT;
        end
      end

      ST_WAIT: begin
        wd_en = 1'b1;
        // A late mem_valid coinciding with expiry is a normal completion.
        if (bus.mem_valid) begin
          if (owner_q == OWN_IF) if_rdata_d = bus.mem_rdata;
          else if (!we_q)        dm_rdata_d = bus.mem_rdata;
          state_d = ST_RESP;
        end else if (wd_expired) begin
          if (owner_q == OWN_IF) if_rdata_d = '0;
          else                   dm_rdata_d = '0;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      mem_en_q   <= 1'b0;
      last_dm_q  <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      mem_en_q   <= mem_en_d;
      last_dm_q  <= last_dm_d;
      to_q       <= to_d;
    end
  end
endmodule
